// File: rtl/pal_pkg.sv
// Shared constants for the sequential palindrome checker: FSM encoding and index-width helper.
package pal_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Width of a register that holds a bit index into a width-bit word.
  function automatic int pal_idx_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/pal_seq_checker_if.sv
// Producer/consumer handshake bundle for pal_seq_checker (request side, result side, status).
interface pal_seq_checker_if
  import pal_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int IDX_W = pal_idx_w(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_is_pal;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W:0]   out_pairs;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_is_pal, out_data, out_pairs, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_is_pal, out_data, out_pairs, busy
  );
endinterface

// File: rtl/pal_msb_scan.sv
// One leading-zero step: reports whether data[hi] is the MSB, whether hi bottomed out, and hi-1.
module pal_msb_scan
  import pal_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = pal_idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [IDX_W-1:0] hi,
  output logic [IDX_W-1:0] hi_next,
  output logic             found,
  output logic             at_zero
);
  assign found   = data[hi];
  assign at_zero = (hi == '0);
  assign hi_next = hi - 1'b1;
endmodule

// File: rtl/pal_seq_checker.sv
// Sequential binary-palindrome checker, one mirrored bit pair per clock with early exit.
// Define PAL_STRIP_LZ_EN to skip leading zeros (number-value palindrome) via a SCAN state.
module pal_seq_checker
  import pal_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  pal_seq_checker_if.slave  bus
);
  localparam int IDX_W = pal_idx_w(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] data;
  logic [IDX_W-1:0] lo, hi;
  logic [IDX_W:0]   pairs;
  logic [IDX_W:0]   span;
  logic             is_pal;

  // Extra headroom bit so a distance of 2 is representable even when IDX_W is 1.
  assign span = {1'b0, hi} - {1'b0, lo};

`ifdef PAL_STRIP_LZ_EN
  logic [IDX_W-1:0] scan_hi;
  logic             scan_found, scan_zero;

  pal_msb_scan #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_scan (
    .data    (data),
    .hi      (hi),
    .hi_next (scan_hi),
    .found   (scan_found),
    .at_zero (scan_zero)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      data   <= '0;
      lo     <= '0;
      hi     <= '0;
      pairs  <= '0;
      is_pal <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          data   <= bus.in_data;
          lo     <= '0;
          hi     <= IDX_W'(WIDTH - 1);
          pairs  <= '0;
          is_pal <= 1'b0;
`ifdef PAL_STRIP_LZ_EN
          state  <= SCAN;
`else
          state  <= CHECK;
`endif
        end
`ifdef PAL_STRIP_LZ_EN
        SCAN: begin
          if (scan_zero) begin
            is_pal <= 1'b1;
            pairs  <= '0;
            state  <= RESP;
          end else if (scan_found) begin
            lo    <= '0;
            state <= CHECK;
          end else begin
            hi <= scan_hi;
          end
        end
`endif
        CHECK: begin
          pairs <= pairs + (IDX_W+1)'(1);
          if (data[lo] != data[hi]) begin
            is_pal <= 1'b0;
            state  <= RESP;
          end else if (span <= (IDX_W+1)'(2)) begin
            // Any remaining middle bit mirrors itself.
            is_pal <= 1'b1;
            state  <= RESP;
          end else begin
            lo <= lo + 1'b1;
            hi <= hi - 1'b1;
          end
        end
        RESP: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.out_valid  = (state == RESP);
  assign bus.out_is_pal = is_pal;
  assign bus.out_data   = data;
  assign bus.out_pairs  = pairs;

endmodule

// File: doc/pal_seq_checker.md
Name: pal_seq_checker

Overview:
- Sequential, handshaked controller that checks whether a WIDTH-bit number is a binary palindrome.
- Compares one mirrored bit pair per clock (bit lo vs bit hi) using a single shared comparator, and exits early on the first mismatch.
- Sits between a number producer (valid/ready in) and a result consumer (valid/ready out). It replaces the wide combinational checker when WIDTH is large or a status/latency trace is needed.

Parameters:
- WIDTH, 8, input word width in bits; must be >= 2; odd and even both legal.
- IDX_W, $clog2(WIDTH), width of the lo/hi index registers (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts a word; high only in IDLE.
- in_data  in  WIDTH  number to check.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_is_pal  out  1  1 = palindrome.
- out_data  out  WIDTH  echo of the checked word.
- out_pairs  out  IDX_W+1  number of bit pairs compared, including a mismatching pair.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: synchronous on rst=1 at the clock edge. Effects:
  - state=IDLE; out_valid=0, out_is_pal=0, out_data=0, out_pairs=0, busy=0, in_ready=1 after the edge.
  - Reset mid-operation abandons the word; no result is produced.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data, lo=0, hi=WIDTH-1, pairs=0, then go to CHECK (or SCAN under macro).
  - CHECK: compare data[lo] vs data[hi] each cycle; pairs increments every compare cycle.
    - Mismatch: is_pal=0, go to RESP.
    - Match with (hi-lo)<=2: is_pal=1, go to RESP. The remaining middle bit, if any, is ignored.
    - Match otherwise: lo+1, hi-1, stay in CHECK.
  - RESP: out_valid=1. out_is_pal, out_data and out_pairs stay stable until out_valid&&out_ready, then go to IDLE.
    - No same-cycle re-accept; in_ready rises the cycle after the result handshake.
- Latency, counted from the accept edge:
  - out_valid rises k edges later, where k = pairs compared.
  - Full palindrome: k = floor(WIDTH/2). WIDTH=8 gives 4; WIDTH=7 gives 3.
- in_valid and in_data are ignored outside IDLE. out_ready is ignored outside RESP.
- Indices never wrap: lo < hi always holds in CHECK.

Optional Feature:
- Macro: PAL_STRIP_LZ_EN. Purpose: number-value palindrome, ignoring leading zeros.
- With the macro, a SCAN state is inserted between IDLE and CHECK. SCAN examines data[hi] once per cycle:
  - data[hi]==0 and hi>0: hi-1, stay in SCAN.
  - data[hi]==1 and hi>0: go to CHECK with lo=0.
  - hi==0 (value 0 or 1): is_pal=1, pairs=0, go to RESP.
- With the macro, latency = (WIDTH-1-msb_index) scan cycles + 1 + compare cycles. For value 0 or 1, latency = WIDTH scan cycles.
- Without the macro, no SCAN state exists and the full WIDTH bits are compared. Leading zeros count as bits.

Decomposition:
- Shared package pal_pkg holds:
  - state encoding constants: IDLE=0, SCAN=1, CHECK=2, RESP=3 (2-bit);
  - the index-width helper function.
- One natural sub-module, pal_msb_scan: the leading-zero step logic (hi-decrement and found flag). It is instantiated only under PAL_STRIP_LZ_EN.
- The FSM, pair compare and handshake stay in the top module.

Test Plan:
- 8'b10000001, out_ready=1 -> out_valid 4 edges after accept; out_is_pal=1, out_pairs=4, out_data=8'h81.
- 8'b10011100 -> mismatch on pair 0 (bit0=0, bit7=1); out_valid 1 edge after accept; out_is_pal=0, out_pairs=1.
- 8'b11000111 -> pairs 0 and 1 match, pair 2 (bit2=1, bit5=0) mismatches; out_is_pal=0, out_pairs=3 after 3 edges.
- 8'b10100101 with out_ready held low 3 cycles -> out_valid, out_is_pal=1 and out_pairs=4 stay stable. in_ready=0 and a concurrent in_valid=1 with 8'hFF is ignored. After the handshake, in_ready=1 the next cycle.
- Assert rst for one edge during CHECK of 8'b11111111 -> next cycle state=IDLE, out_valid=0, in_ready=1. Then 8'b11000011 -> out_is_pal=1, out_pairs=4.
- PAL_STRIP_LZ_EN with 8'b00001001 -> 4 scan decrement cycles, then 2 compares. Result: out_is_pal=1, out_pairs=2.
  - 8'h00 -> out_is_pal=1, out_pairs=0.
  - Without the macro, 8'b00001001 gives out_is_pal=0, out_pairs=1.
